// File: rtl/muldiv_scheduler.sv
// Shares one iterative multiplier and one divider between the two issue slots,
// issuing in program order and returning each 64-bit result as a HI/LO write.
module muldiv_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [1:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   input  logic [1:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        flush,
   output logic        stall,
   output logic        mul_start,
   output logic        mul_sign,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic        mul_ready,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic        div_annul,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        hilo_we,
   output logic [63:0] hilo_wdata,
   output logic        hilo_slot
);

   typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DRAIN} state_t;

   state_t      state_reg, state_next;
   logic        done0_reg, done0_next;
   logic        done1_reg, done1_next;
   logic [1:0]  op_reg;
   logic [31:0] a_reg, b_reg;
   logic        slot_reg;
   logic        mul_ready_q, div_ready_q;
   logic        mul_acc, div_acc;
   logic        pend0, pend1;
   logic        issue, issue_slot;
   logic        wr_en;
   logic [63:0] wr_data;

   assign pend0 = req0_valid & ~done0_reg;
   assign pend1 = req1_valid & ~done1_reg;
   assign stall = (state_reg == DRAIN) | ((pend0 | pend1) & ~flush);

   // Only the first high cycle of ready counts, so level-style units work too.
   assign mul_acc = mul_ready & ~mul_ready_q;
   assign div_acc = div_ready & ~div_ready_q;

   always_comb begin
      state_next = state_reg;
      done0_next = done0_reg;
      done1_next = done1_reg;
      issue      = 1'b0;
      issue_slot = 1'b0;
      wr_en      = 1'b0;
      wr_data    = 64'd0;
      mul_start  = 1'b0;
      mul_sign   = 1'b0;
      mul_a      = 32'd0;
      mul_b      = 32'd0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_annul  = 1'b0;
      div_a      = 32'd0;
      div_b      = 32'd0;

      case (state_reg)
         IDLE: begin
            if (!flush && (pend0 || pend1)) begin
               issue      = 1'b1;
               issue_slot = ~pend0;
            end
         end
         MUL_BUSY: begin
            mul_start = 1'b1;
            mul_sign  = ~op_reg[0];
            mul_a     = a_reg;
            mul_b     = b_reg;
            // A flushed multiply that is not finishing yet must still be drained.
            if (flush)
               state_next = mul_acc ? IDLE : DRAIN;
            else if (mul_acc) begin
               wr_en      = 1'b1;
               wr_data    = mul_result;
               state_next = IDLE;
            end
         end
         DIV_BUSY: begin
            div_start  = ~flush;
            div_signed = ~op_reg[0];
            div_annul  = flush;
            div_a      = a_reg;
            div_b      = b_reg;
            if (flush)
               state_next = IDLE;
            else if (div_acc) begin
               wr_en      = 1'b1;
               wr_data    = div_result;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (mul_acc)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (wr_en) begin
         if (slot_reg == 1'b0)
            done0_next = 1'b1;
         else
            done1_next = 1'b1;
      end

      // Slot 1 issues in the same edge slot 0 completes, keeping the write slot free of bubbles.
      if (wr_en && slot_reg == 1'b0 && pend1) begin
         issue      = 1'b1;
         issue_slot = 1'b1;
      end

      if (issue)
         state_next = (issue_slot ? req1_op[1] : req0_op[1]) ? DIV_BUSY : MUL_BUSY;

      if (flush || !stall) begin
         done0_next = 1'b0;
         done1_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         done0_reg   <= 1'b0;
         done1_reg   <= 1'b0;
         op_reg      <= 2'd0;
         a_reg       <= 32'd0;
         b_reg       <= 32'd0;
         slot_reg    <= 1'b0;
         mul_ready_q <= 1'b0;
         div_ready_q <= 1'b0;
         hilo_we     <= 1'b0;
         hilo_wdata  <= 64'd0;
         hilo_slot   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         done0_reg   <= done0_next;
         done1_reg   <= done1_next;
         mul_ready_q <= mul_ready;
         div_ready_q <= div_ready;
         hilo_we     <= wr_en;
         if (wr_en) begin
            hilo_wdata <= wr_data;
            hilo_slot  <= slot_reg;
         end
         if (issue) begin
            op_reg   <= issue_slot ? req1_op : req0_op;
            a_reg    <= issue_slot ? req1_a : req0_a;
            b_reg    <= issue_slot ? req1_b : req0_b;
            slot_reg <= issue_slot;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler with simple latency models of the
// multiplier and divider; expected HI/LO values are hand-computed constants.
module tb_muldiv_scheduler;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 8;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        flush;
   logic        stall;
   logic        mul_start, mul_sign;
   logic [31:0] mul_a, mul_b;
   logic        mul_ready;
   logic [63:0] mul_result;
   logic        div_start, div_signed, div_annul;
   logic [31:0] div_a, div_b;
   logic        div_ready;
   logic [63:0] div_result;
   logic        hilo_we;
   logic [63:0] hilo_wdata;
   logic        hilo_slot;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_scheduler dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .flush(flush), .stall(stall),
      .mul_start(mul_start), .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b),
      .mul_ready(mul_ready), .mul_result(mul_result),
      .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
      .div_a(div_a), .div_b(div_b), .div_ready(div_ready), .div_result(div_result),
      .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .hilo_slot(hilo_slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- unit models ----------------
   function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
      logic [63:0] ea, eb;
      ea = s ? {{32{a[31]}}, a} : {32'd0, a};
      eb = s ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
      logic signed [31:0] sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = a; sb = b;
         q = sa / sb;
         r = sa % sb;
         return {r, q};
      end
      return {a % b, a / b};
   endfunction

   logic        m_busy, d_busy;
   int          m_cnt, d_cnt;
   logic [63:0] m_res, d_res;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_cnt <= 0; mul_ready <= 1'b0; mul_result <= 64'd0; m_res <= 64'd0;
      end else begin
         mul_ready <= 1'b0;
         if (m_busy) begin
            if (m_cnt == MUL_LAT) begin
               m_busy <= 1'b0; mul_ready <= 1'b1; mul_result <= m_res;
            end else
               m_cnt <= m_cnt + 1;
         end else if (mul_start && !mul_ready) begin
            m_busy <= 1'b1; m_cnt <= 1; m_res <= mul_model(mul_a, mul_b, mul_sign);
         end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         d_busy <= 1'b0; d_cnt <= 0; div_ready <= 1'b0; div_result <= 64'd0; d_res <= 64'd0;
      end else begin
         div_ready <= 1'b0;
         if (div_annul)
            d_busy <= 1'b0;
         else if (d_busy) begin
            if (d_cnt == DIV_LAT) begin
               d_busy <= 1'b0; div_ready <= 1'b1; div_result <= d_res;
            end else
               d_cnt <= d_cnt + 1;
         end else if (div_start && !div_ready) begin
            d_busy <= 1'b1; d_cnt <= 1; d_res <= div_model(div_a, div_b, div_signed);
         end
      end
   end

   // ---------------- monitor ----------------
   int          wr_cnt = 0;
   int          annul_cnt = 0;
   int          both_cnt = 0;
   int          sign_low_cnt = 0;
   int          start_cnt = 0;
   logic [63:0] wr_data_log [16];
   logic        wr_slot_log [16];
   logic        wr_stall_log[16];

   always @(negedge clk) begin
      if (hilo_we) begin
         if (wr_cnt < 16) begin
            wr_data_log[wr_cnt]  = hilo_wdata;
            wr_slot_log[wr_cnt]  = hilo_slot;
            wr_stall_log[wr_cnt] = stall;
         end
         $display("hilo write #%0d: slot %0d data %h stall %0d", wr_cnt, hilo_slot, hilo_wdata, stall);
         wr_cnt++;
      end
      if (div_annul) annul_cnt++;
      if (mul_start && div_start) both_cnt++;
      if (mul_start) begin
         start_cnt++;
         if (!mul_sign) sign_low_cnt++;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic set_req0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
   endtask

   // Wait for the group to finish, let the monitor see that cycle, then retire it.
   task automatic wait_group(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         #2;
         if (!stall) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_done"}, 64'(ok), 64'd1);
      #3;
      clear_reqs();
   endtask

   int base;

   initial begin
      rst = 1'b1; flush = 1'b0;
      req0_valid = 1'b0; req0_op = 2'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_op = 2'd0; req1_a = 32'd0; req1_b = 32'd0;
      #3;
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_hilo_we", 64'(hilo_we), 64'd0);
      check("rst_hilo_wdata", hilo_wdata, 64'd0);
      check("rst_mul_start", 64'(mul_start), 64'd0);
      check("rst_div_start", 64'(div_start), 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // 1: slot 0 MULT -7 * 3
      base = wr_cnt; start_cnt = 0; sign_low_cnt = 0;
      set_req0(2'b00, 32'hFFFF_FFF9, 32'd3);
      #2;
      check("t1_stall_req", 64'(stall), 64'd1);
      tick(); #2;
      check("t1_mul_start", 64'(mul_start), 64'd1);
      wait_group("t1");
      repeat (3) tick();
      check("t1_wr_count", 64'(wr_cnt - base), 64'd1);
      check("t1_data", wr_data_log[base], 64'hFFFF_FFFF_FFFF_FFEB);
      check("t1_slot", 64'(wr_slot_log[base]), 64'd0);
      check("t1_stall_at_we", 64'(wr_stall_log[base]), 64'd0);
      check("t1_sign_low", 64'(sign_low_cnt), 64'd0);
      check("t1_start_seen", 64'(start_cnt > 0), 64'd1);

      // 2: group {slot 0 MULTU FFFFFFFF*2, slot 1 DIV 7/-2}
      base = wr_cnt; both_cnt = 0;
      set_req0(2'b01, 32'hFFFF_FFFF, 32'd2);
      req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'd7; req1_b = 32'hFFFF_FFFE;
      wait_group("t2");
      repeat (3) tick();
      check("t2_wr_count", 64'(wr_cnt - base), 64'd2);
      check("t2_data0", wr_data_log[base], 64'h0000_0001_FFFF_FFFE);
      check("t2_slot0", 64'(wr_slot_log[base]), 64'd0);
      check("t2_stall0", 64'(wr_stall_log[base]), 64'd1);
      check("t2_data1", wr_data_log[base+1], 64'h0000_0001_FFFF_FFFD);
      check("t2_slot1", 64'(wr_slot_log[base+1]), 64'd1);
      check("t2_stall1", 64'(wr_stall_log[base+1]), 64'd0);
      check("t2_start_overlap", 64'(both_cnt), 64'd0);

      // 3: DIVU 100/0 forwards the divider result untouched
      base = wr_cnt;
      set_req0(2'b11, 32'd100, 32'd0);
      wait_group("t3");
      repeat (3) tick();
      check("t3_wr_count", 64'(wr_cnt - base), 64'd1);
      check("t3_data", hilo_wdata, 64'h0000_0064_FFFF_FFFF);

      // 4: DIV flushed in flight, then a MULT issues right away
      base = wr_cnt; annul_cnt = 0;
      set_req0(2'b10, 32'd50, 32'd5);
      tick();
      repeat (4) tick();
      flush = 1'b1;
      #2;
      check("t4_annul", 64'(div_annul), 64'd1);
      check("t4_div_start_off", 64'(div_start), 64'd0);
      check("t4_stall_flush", 64'(stall), 64'd0);
      tick();
      flush = 1'b0;
      set_req0(2'b00, 32'd6, 32'd7);
      #2;
      check("t4_annul_gone", 64'(div_annul), 64'd0);
      tick(); #2;
      check("t4_mul_issue", 64'(mul_start), 64'd1);
      wait_group("t4");
      repeat (3) tick();
      check("t4_annul_cycles", 64'(annul_cnt), 64'd1);
      check("t4_wr_count", 64'(wr_cnt - base), 64'd1);
      check("t4_data", wr_data_log[base], 64'd42);

      // 5: MULT flushed in flight drains before the next request issues
      base = wr_cnt;
      set_req0(2'b00, 32'd2, 32'd3);
      tick();
      tick();
      flush = 1'b1; clear_reqs();
      tick();
      flush = 1'b0;
      #2;
      check("t5_drain_stall", 64'(stall), 64'd1);
      check("t5_drain_start", 64'(mul_start), 64'd0);
      set_req0(2'b01, 32'd3, 32'd4);
      wait_group("t5");
      repeat (3) tick();
      check("t5_wr_count", 64'(wr_cnt - base), 64'd1);
      check("t5_data", wr_data_log[base], 64'd12);

      // 6: asynchronous reset in the middle of a divide
      set_req0(2'b10, 32'd9, 32'd2);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("t6_rst_div_start", 64'(div_start), 64'd0);
      check("t6_rst_hilo_wdata", hilo_wdata, 64'd0);
      check("t6_rst_hilo_we", 64'(hilo_we), 64'd0);
      check("t6_rst_stall", 64'(stall), 64'd1);
      clear_reqs();
      tick();
      rst = 1'b0;
      tick();
      base = wr_cnt;
      set_req0(2'b01, 32'd3, 32'd5);
      wait_group("t6");
      repeat (3) tick();
      check("t6_wr_count", 64'(wr_cnt - base), 64'd1);
      check("t6_data", wr_data_log[base], 64'h0000_0000_0000_000F);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
